// File: rtl/ervp_multi_tick_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package ervp_multi_tick_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ch_state_e;

    // Zero-valued dividers and periods behave as 1.
    function automatic logic [31:0] eff_val(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/ervp_tick_channel.sv
// One tick channel: divides the base tick by a programmable period,
// periodic or one-shot, with a wrapping tick counter.
module ervp_tick_channel
    import ervp_multi_tick_pkg::*;
#(
    parameter int unsigned BW_PERIOD   = 16,
    parameter int unsigned BW_TICK_CNT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   base_tick,
    input  logic [BW_PERIOD-1:0]   period,
    input  logic                   ch_enable,
    input  logic                   oneshot,
    input  logic                   restart,
    output logic                   tick,
    output logic                   active,
    output logic [BW_TICK_CNT-1:0] count
);

    ch_state_e              state_q, state_d;
    logic [BW_PERIOD-1:0]   cc_q, cc_d;
    logic [BW_TICK_CNT-1:0] cnt_q, cnt_d;
    logic [BW_PERIOD-1:0]   p_eff;
    logic                   period_hit;

    assign p_eff      = BW_PERIOD'(eff_val(32'(period)));
    // >= rather than == so a period lowered below cc fires instead of locking up.
    assign period_hit = (cc_q >= p_eff);

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (enable) begin
            if (!ch_enable) begin
                state_d = StIdle;
                cc_d    = BW_PERIOD'(1);
            end else if (restart) begin
                state_d = StRun;
                cc_d    = BW_PERIOD'(1);
                cnt_d   = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_d = StRun;
                        cc_d    = BW_PERIOD'(1);
                        cnt_d   = '0;
                    end
                    StRun: begin
                        if (base_tick) begin
                            if (period_hit) begin
                                tick  = 1'b1;
                                cc_d  = BW_PERIOD'(1);
                                cnt_d = cnt_q + BW_TICK_CNT'(1);
                                if (oneshot) begin
                                    state_d = StDone;
                                end
                            end else begin
                                cc_d = cc_q + BW_PERIOD'(1);
                            end
                        end
                    end
                    StDone: begin
                        state_d = StDone;
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cc_q    <= BW_PERIOD'(1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active = (state_q == StRun);
    assign count  = cnt_q;

endmodule

// File: rtl/ervp_multi_tick_generator.sv
// Runtime-programmable prescaler producing a base tick, feeding NUM_CH
// independent divide-by-period tick channels.
module ervp_multi_tick_generator
    import ervp_multi_tick_pkg::*;
#(
    parameter int unsigned BW_PRESCALE = 10,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned BW_PERIOD   = 16,
    parameter int unsigned BW_TICK_CNT = 8
) (
    input  logic                            clk,
    input  logic                            rstpp,
    input  logic                            enable,
    input  logic [BW_PRESCALE-1:0]          prescale_div,
    input  logic [NUM_CH*BW_PERIOD-1:0]     ch_period,
    input  logic [NUM_CH-1:0]               ch_enable,
    input  logic [NUM_CH-1:0]               ch_oneshot,
    input  logic [NUM_CH-1:0]               ch_restart,
    output logic                            base_tick,
    output logic [NUM_CH-1:0]               ch_tick,
    output logic [NUM_CH-1:0]               ch_active,
    output logic [NUM_CH*BW_TICK_CNT-1:0]   ch_tick_count
);

    logic [BW_PRESCALE-1:0] pc_q, pc_d;
    logic [BW_PRESCALE-1:0] d_eff;

    assign d_eff = BW_PRESCALE'(eff_val(32'(prescale_div)));
    // Gated by reset so no pulse escapes while pc sits at its reset value.
    assign base_tick = enable & ~rstpp & (pc_q >= d_eff);

    always_comb begin
        pc_d = pc_q;
        if (base_tick) begin
            pc_d = BW_PRESCALE'(1);
        end else if (enable) begin
            pc_d = pc_q + BW_PRESCALE'(1);
        end
    end

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            pc_q <= BW_PRESCALE'(1);
        end else begin
            pc_q <= pc_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ervp_tick_channel #(
            .BW_PERIOD   (BW_PERIOD),
            .BW_TICK_CNT (BW_TICK_CNT)
        ) u_ch (
            .clk       (clk),
            .rst       (rstpp),
            .enable    (enable),
            .base_tick (base_tick),
            .period    (ch_period[i*BW_PERIOD +: BW_PERIOD]),
            .ch_enable (ch_enable[i]),
            .oneshot   (ch_oneshot[i]),
            .restart   (ch_restart[i]),
            .tick      (ch_tick[i]),
            .active    (ch_active[i]),
            .count     (ch_tick_count[i*BW_TICK_CNT +: BW_TICK_CNT])
        );
    end

endmodule
